pulse_gen: RTL

PULSE_GEN -- requirements
Module: pulse_gen

---
 rtl/pulse_gen.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pulse_gen.sv
// rtl/pulse_gen.sv - triangular-ish DAC pulse generator: linear rise, exponential fall, dead gap.
// Optional periodic self-trigger enabled by macro PULSE_GEN_AUTO_EN.
module pulse_gen #(
   parameter int unsigned RISE_SHIFT  = 2,
   parameter int unsigned TAU_SHIFT   = 4,
   parameter int unsigned DEAD_CYCLES = 16,
   parameter logic [13:0] BASELINE    = 14'd0
) (
   input  logic        CLOCK_100,
   input  logic        rst_n,
   input  logic        start,
   input  logic [13:0] height,
`ifdef PULSE_GEN_AUTO_EN
   input  logic        auto_en,
   input  logic [15:0] period,
`endif
   output logic        busy,
   output logic        pulse_indicator,
   output logic [13:0] da_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RISE = 2'd1,
      FALL = 2'd2,
      GAP  = 2'd3
   } state_t;

   localparam logic [15:0] DEAD_LOAD = 16'(DEAD_CYCLES);

   state_t      state_q, state_d;
   logic [13:0] y_q, y_d;
   logic [13:0] height_q, height_d;
   logic [15:0] gap_q, gap_d;
   logic [13:0] da_q, da_d;

   logic [14:0] step;
   logic [14:0] dec;
   logic [14:0] rise_sum;
   logic [14:0] da_sum;
   logic        trig;
   logic        auto_trig;

`ifdef PULSE_GEN_AUTO_EN
   logic [15:0] auto_cnt_q, auto_cnt_d;

   // Free-running interval counter; it keeps counting even when its trigger is dropped while busy.
   always_comb begin
      auto_cnt_d = 16'd0;
      auto_trig  = 1'b0;
      if (auto_en && (period != 16'd0)) begin
         if (auto_cnt_q >= (period - 16'd1)) begin
            auto_cnt_d = 16'd0;
            auto_trig  = 1'b1;
         end else begin
            auto_cnt_d = auto_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge CLOCK_100 or negedge rst_n) begin
      if (!rst_n) begin
         auto_cnt_q <= 16'd0;
      end else begin
         auto_cnt_q <= auto_cnt_d;
      end
   end
`else
   assign auto_trig = 1'b0;
`endif

   assign trig = start | auto_trig;

   // 15-bit datapath so y + step and BASELINE + y can never wrap.
   always_comb begin
      step = {1'b0, (height_q >> RISE_SHIFT)};
      if (step == 15'd0) begin
         step = 15'd1;
      end
      dec = {1'b0, (y_q >> TAU_SHIFT)};
      if (dec == 15'd0) begin
         dec = 15'd1;
      end
      rise_sum = {1'b0, y_q} + step;
      da_sum   = {1'b0, BASELINE} + {1'b0, y_q};
   end

   always_comb begin
      state_d  = state_q;
      y_d      = y_q;
      height_d = height_q;
      gap_d    = gap_q;
      case (state_q)
         IDLE: begin
            if (trig && (height != 14'd0)) begin
               height_d = height;
               y_d      = 14'd0;
               state_d  = RISE;
            end
         end
         RISE: begin
            if (rise_sum >= {1'b0, height_q}) begin
               y_d     = height_q;
               state_d = FALL;
            end else begin
               y_d = rise_sum[13:0];
            end
         end
         FALL: begin
            if ({1'b0, y_q} <= dec) begin
               y_d = 14'd0;
               if (DEAD_CYCLES == 0) begin
                  state_d = IDLE;
               end else begin
                  state_d = GAP;
                  gap_d   = DEAD_LOAD;
               end
            end else begin
               y_d = y_q - dec[13:0];
            end
         end
         GAP: begin
            if (gap_q <= 16'd1) begin
               gap_d   = 16'd0;
               state_d = IDLE;
            end else begin
               gap_d = gap_q - 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      da_d = da_sum[14] ? 14'h3FFF : da_sum[13:0];
   end

   always_ff @(posedge CLOCK_100 or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         y_q      <= 14'd0;
         height_q <= 14'd0;
         gap_q    <= 16'd0;
         da_q     <= BASELINE;
      end else begin
         state_q  <= state_d;
         y_q      <= y_d;
         height_q <= height_d;
         gap_q    <= gap_d;
         da_q     <= da_d;
      end
   end

   assign busy            = (state_q != IDLE);
   assign pulse_indicator = (state_q == RISE);
   assign da_data         = da_q;

endmodule
